alu_result_stage: RTL and testbench
===================================

ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 SHALL have parameter RSTATUS_REG, default 30, meaning the register index written on an overflow exception.
REQ-002 SHALL have parameter CNT_W, default 16, meaning the width of the exception counter.
REQ-003 SHALL have port clock, input, 1 bit: single clock, all state updates on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit: the upstream ALU beat is valid.
REQ-006 SHALL have port in_ready, output, 1 bit: the stage can accept a beat.
REQ-007 SHALL have port in_result, input, 32 bits: ALU data_result.
REQ-008 SHALL have ports in_isNotEqual, in_isLessThan and in_overflow, inputs, 1 bit each: ALU flags.
REQ-009 SHALL have port in_kind, input, 3 bits: 0=ADD, 1=ADDI, 2=SUB, 3=BNE, 4=BLT, 5=OTHER (writes rd, no exception); values 6-7 are treated as OTHER.
REQ-010 SHALL have ports in_rd, input, 5 bits (destination register) and in_target, input, 32 bits (branch target PC).
REQ-011 SHALL have port out_valid, output, 1 bit, and port out_ready, input, 1 bit: downstream handshake.
REQ-012 SHALL have ports out_we, output, 1 bit; out_rd, output, 5 bits; and out_data, output, 32 bits: the writeback request.
REQ-013 SHALL have ports out_redirect, output, 1 bit, and out_target, output, 32 bits: taken-branch redirect.
REQ-014 SHALL have port exc_count, output, CNT_W bits: overflow exceptions retired.

Function
REQ-015 SHALL accept a beat when in_valid and in_ready are both high, and SHALL retire a beat when out_valid and out_ready are both high.
REQ-016 SHALL buffer beats in a 2-entry FIFO with states EMPTY, ONE and TWO.
REQ-017 SHALL make transitions as follows: EMPTY to ONE on accept; ONE to TWO on accept without retire; ONE to EMPTY on retire without accept; TWO to ONE on retire; ONE stays ONE on a simultaneous accept and retire.
REQ-018 SHALL drive in_ready as a registered signal equal to (state != TWO), with no combinational path from out_ready.
REQ-019 SHALL drive out_valid = (state != EMPTY) and present the head entry on the outputs; latency from accept to out_valid SHALL be 1 cycle.
REQ-020 SHALL hold the head entry's outputs stable while out_valid=1 and out_ready=0.
REQ-021 SHALL compute the overflow exception at accept time: for kinds ADD, ADDI and SUB with in_overflow=1, the entry SHALL get rd=RSTATUS_REG and data=1, 2 or 3 respectively, with we=1.
REQ-022 SHALL ignore in_overflow for all other kinds.
REQ-023 SHALL, for kinds ADD, ADDI, SUB and OTHER without exception, set rd=in_rd, data=in_result, and we=(in_rd != 0).
REQ-024 SHALL set we=0 for BNE and BLT.
REQ-025 SHALL set redirect to in_isNotEqual for BNE and to in_isLessThan for BLT, and to 0 for all other kinds; target SHALL be in_target.
REQ-026 SHALL gate out_redirect and out_we with out_valid, so both are 0 when out_valid is 0.
REQ-027 SHALL increment exc_count by 1 on each retire of an exception entry, saturating at all-ones.
REQ-028 SHALL allow simultaneous accept and retire in state ONE, with no beat lost or duplicated.

Reset
REQ-029 SHALL, when reset_n=0 at a rising edge, set state to EMPTY, in_ready to 1, out_valid to 0, out_we to 0, out_redirect to 0 and exc_count to 0.
REQ-030 SHALL discard entries held in the FIFO when reset occurs mid-operation.
REQ-031 SHALL drive out_data, out_rd and out_target to 0 after reset.
REQ-032 SHALL give reset priority over any concurrent handshake.

Structure
REQ-033 SHALL place the in_kind encodings and the exception codes (1, 2, 3) in the shared package alu_pkg.
REQ-034 SHALL implement the FIFO as one sub-module, skid_fifo2, which is 2 entries deep and parameterized by payload width.
REQ-035 SHALL implement the decode of exception and redirect combinationally ahead of the FIFO write.

Verification
REQ-036 Bench SHALL cover: ADD, in_result=32'h00000002, in_rd=5, no overflow, out_ready=1 -> one cycle later out_valid=1, out_we=1, out_rd=5, out_data=32'h00000002; exc_count stays 0.
REQ-037 Bench SHALL cover: ADD with in_overflow=1 (operands 32'h80000000+32'h80000000), then SUB with in_overflow=1 -> out_rd=30 with out_data=1, then out_rd=30 with out_data=3; exc_count=2.
REQ-038 Bench SHALL cover: BLT with in_isLessThan=1 and in_target=32'h00000040, then BNE with in_isNotEqual=0 -> out_redirect=1 with out_target=32'h00000040, then out_redirect=0; out_we=0 on both beats.
REQ-039 Bench SHALL cover: out_ready=0 while 3 beats are offered back-to-back -> in_ready=0 after 2 accepts; after out_ready=1 the beats retire in order with none lost or duplicated.
REQ-040 Bench SHALL cover: in_valid=1 and out_ready=1 held for 10 cycles -> 10 beats retired, state stays ONE, throughput is 1 beat per cycle.
REQ-041 Bench SHALL cover: reset_n=0 for 1 cycle while in state TWO -> the next cycle has out_valid=0, in_ready=1 and exc_count=0; an OTHER beat with in_rd=0 afterwards -> out_we=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result stage: instruction-kind encodings,
// overflow exception codes, FIFO states and the buffered entry layout.
package alu_pkg;

  // Encoding of the in_kind field delivered alongside each ALU beat.
  typedef enum logic [2:0] {
    KIND_ADD   = 3'd0,
    KIND_ADDI  = 3'd1,
    KIND_SUB   = 3'd2,
    KIND_BNE   = 3'd3,
    KIND_BLT   = 3'd4,
    KIND_OTHER = 3'd5
  } alu_kind_e;

  // Value written to the status register when an arithmetic op overflows.
  localparam logic [31:0] EXC_CODE_ADD  = 32'd1;
  localparam logic [31:0] EXC_CODE_ADDI = 32'd2;
  localparam logic [31:0] EXC_CODE_SUB  = 32'd3;

  // Occupancy states of the two-entry output buffer.
  typedef enum logic [1:0] {
    FIFO_EMPTY = 2'd0,
    FIFO_ONE   = 2'd1,
    FIFO_TWO   = 2'd2
  } fifo_state_e;

  // One decoded beat as held in the buffer.
  typedef struct packed {
    logic        exc;       // entry is an overflow exception
    logic        we;        // register write requested
    logic [4:0]  rd;        // destination register
    logic [31:0] data;      // writeback data
    logic        redirect;  // taken branch
    logic [31:0] target;    // branch target PC
  } result_entry_t;

  // Unused encodings 6 and 7 behave exactly like OTHER.
  function automatic alu_kind_e normalize_kind(input logic [2:0] raw);
    if (raw > 3'd5) return KIND_OTHER;
    return alu_kind_e'(raw);
  endfunction

  // Exception code for the arithmetic kinds; zero for anything else.
  function automatic logic [31:0] exc_code(input alu_kind_e kind);
    case (kind)
      KIND_ADD:  return EXC_CODE_ADD;
      KIND_ADDI: return EXC_CODE_ADDI;
      KIND_SUB:  return EXC_CODE_SUB;
      default:   return 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/skid_fifo2.sv
// Two-entry FIFO with a registered push_ready, so upstream backpressure
// never depends combinationally on pop_ready.
module skid_fifo2
  import alu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         push_valid,
  output logic         push_ready,
  input  logic [W-1:0] push_data,
  output logic         pop_valid,
  input  logic         pop_ready,
  output logic [W-1:0] pop_data
);

  fifo_state_e  state_q;
  fifo_state_e  state_d;
  logic         ready_q;
  logic [W-1:0] head_q;
  logic [W-1:0] tail_q;
  logic         push;
  logic         pop;

  assign push       = push_valid & ready_q;
  assign pop        = pop_valid & pop_ready;
  assign pop_valid  = (state_q != FIFO_EMPTY);
  assign push_ready = ready_q;
  assign pop_data   = head_q;

  // Next occupancy from the accept/retire pair of this cycle.
  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    case (state_q)
      FIFO_EMPTY: if (push) state_d = FIFO_ONE;
      FIFO_ONE: begin
        if (push && !pop)      state_d = FIFO_TWO;
        else if (!push && pop) state_d = FIFO_EMPTY;
      end
      FIFO_TWO:   if (pop) state_d = FIFO_ONE;
      default:    state_d = FIFO_EMPTY;
    endcase
  end

  // State register; push_ready is registered from the next state.
  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments keep all flops updating from pre-edge values.
    if (!reset_n) begin
      state_q <= FIFO_EMPTY;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d != FIFO_TWO);
    end
  end

  // Payload slots: head is always the oldest entry, tail the second one.
  always_ff @(posedge clock) begin
    // NOTE: the slots are reset because the head drives visible outputs that must read 0 after reset.
    if (!reset_n) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      case (state_q)
        FIFO_EMPTY: if (push) head_q <= push_data;
        FIFO_ONE: begin
          if (push && pop) head_q <= push_data;
          else if (push)   tail_q <= push_data;
        end
        FIFO_TWO:   if (pop) head_q <= tail_q;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/alu_result_stage.sv
// ALU result stage: decodes overflow exceptions and branch redirects from
// an ALU beat, buffers the result in a two-entry FIFO and presents it as a
// writeback/redirect request; counts retired overflow exceptions.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int RSTATUS_REG = 30,
  parameter int CNT_W       = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_result,
  input  logic             in_isNotEqual,
  input  logic             in_isLessThan,
  input  logic             in_overflow,
  input  logic [2:0]       in_kind,
  input  logic [4:0]       in_rd,
  input  logic [31:0]      in_target,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_we,
  output logic [4:0]       out_rd,
  output logic [31:0]      out_data,
  output logic             out_redirect,
  output logic [31:0]      out_target,
  output logic [CNT_W-1:0] exc_count
);

  localparam logic [4:0] RSTATUS_IDX = 5'(RSTATUS_REG);

  alu_kind_e     kind;
  result_entry_t beat_in;
  result_entry_t head;
  logic          fifo_valid;
  logic          retire;
  logic [CNT_W-1:0] exc_count_q;

  assign kind = normalize_kind(in_kind);

  // Decode the incoming beat into the entry written into the FIFO.
  always_comb begin
    beat_in        = '0;
    beat_in.rd     = in_rd;
    beat_in.data   = in_result;
    beat_in.target = in_target;
    case (kind)
      KIND_ADD, KIND_ADDI, KIND_SUB: begin
        if (in_overflow) begin
          beat_in.exc  = 1'b1;
          beat_in.we   = 1'b1;
          beat_in.rd   = RSTATUS_IDX;
          beat_in.data = exc_code(kind);
        end else begin
          beat_in.we = (in_rd != 5'd0);
        end
      end
      KIND_BNE: beat_in.redirect = in_isNotEqual;
      KIND_BLT: beat_in.redirect = in_isLessThan;
      default:  beat_in.we = (in_rd != 5'd0);
    endcase
  end

  skid_fifo2 #(
    .W($bits(result_entry_t))
  ) u_fifo (
    .clock      (clock),
    .reset_n    (reset_n),
    .push_valid (in_valid),
    .push_ready (in_ready),
    .push_data  (beat_in),
    .pop_valid  (fifo_valid),
    .pop_ready  (out_ready),
    .pop_data   (head)
  );

  assign retire = fifo_valid & out_ready;

  // Saturating count of exception entries retired downstream.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      exc_count_q <= '0;
    end else if (retire && head.exc && (exc_count_q != '1)) begin
      exc_count_q <= exc_count_q + CNT_W'(1);
    end
  end

  assign out_valid    = fifo_valid;
  assign out_we       = fifo_valid & head.we;
  assign out_redirect = fifo_valid & head.redirect;
  assign out_rd       = head.rd;
  assign out_data     = head.data;
  assign out_target   = head.target;
  assign exc_count    = exc_count_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: directed vector table, hand
// sequences for backpressure/throughput/reset, and a randomized run checked
// against a queue-based model of the stage.
module tb_alu_result_stage;

  localparam int TB_CNT_W = 3;
  localparam int CMAX     = (1 << TB_CNT_W) - 1;

  logic                clock = 1'b0;
  logic                reset_n;
  logic                in_valid;
  logic                in_ready;
  logic [31:0]         in_result;
  logic                in_isNotEqual;
  logic                in_isLessThan;
  logic                in_overflow;
  logic [2:0]          in_kind;
  logic [4:0]          in_rd;
  logic [31:0]         in_target;
  logic                out_valid;
  logic                out_ready;
  logic                out_we;
  logic [4:0]          out_rd;
  logic [31:0]         out_data;
  logic                out_redirect;
  logic [31:0]         out_target;
  logic [TB_CNT_W-1:0] exc_count;

  alu_result_stage #(
    .RSTATUS_REG (30),
    .CNT_W       (TB_CNT_W)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_result     (in_result),
    .in_isNotEqual (in_isNotEqual),
    .in_isLessThan (in_isLessThan),
    .in_overflow   (in_overflow),
    .in_kind       (in_kind),
    .in_rd         (in_rd),
    .in_target     (in_target),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_we        (out_we),
    .out_rd        (out_rd),
    .out_data      (out_data),
    .out_redirect  (out_redirect),
    .out_target    (out_target),
    .exc_count     (exc_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        redir;
    logic [31:0] target;
    logic        exc;
    logic        chk;  // rd/data are defined for this entry
  } exp_t;

  typedef struct {
    logic [2:0]  kind;
    logic [31:0] result;
    logic        ne;
    logic        lt;
    logic        ovf;
    logic [4:0]  rd;
    logic [31:0] target;
    logic        we;
    logic [4:0]  erd;
    logic [31:0] edata;
    logic        redir;
    logic        chk;
  } vec_t;

  exp_t        mq[$];
  int          m_cnt;
  logic [31:0] act_log[$];
  bit          last_acc;
  int          n_vec;
  int          n_bad;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected entry for one beat, straight from the kind/overflow rules.
  function automatic exp_t model_decode(input logic [2:0] kind, input logic [31:0] res,
                                        input logic ne, input logic lt, input logic ovf,
                                        input logic [4:0] rd, input logic [31:0] tgt);
    exp_t e;
    int   k;
    k        = (kind > 3'd5) ? 5 : int'(kind);
    e.target = tgt;
    e.redir  = 1'b0;
    e.exc    = 1'b0;
    e.chk    = 1'b1;
    e.rd     = rd;
    e.data   = res;
    e.we     = (rd != 5'd0);
    if (k <= 2 && ovf) begin
      e.exc  = 1'b1;
      e.we   = 1'b1;
      e.rd   = 5'd30;
      e.data = 32'(k + 1);
    end else if (k == 3) begin
      e.we    = 1'b0;
      e.redir = ne;
      e.chk   = 1'b0;
    end else if (k == 4) begin
      e.we    = 1'b0;
      e.redir = lt;
      e.chk   = 1'b0;
    end
    return e;
  endfunction

  task automatic compare_outputs();
    check("out_valid", 32'(out_valid), 32'(mq.size() > 0));
    check("in_ready", 32'(in_ready), 32'(mq.size() < 2));
    check("exc_count", 32'(exc_count), 32'(m_cnt));
    if (mq.size() > 0) begin
      check("out_we", 32'(out_we), 32'(mq[0].we));
      check("out_redirect", 32'(out_redirect), 32'(mq[0].redir));
      check("out_target", out_target, mq[0].target);
      if (mq[0].chk) begin
        check("out_rd", 32'(out_rd), 32'(mq[0].rd));
        check("out_data", out_data, mq[0].data);
      end
    end else begin
      check("out_we_idle", 32'(out_we), 32'd0);
      check("out_redirect_idle", 32'(out_redirect), 32'd0);
    end
  endtask

  // One clock: predict handshakes, advance the model, compare after the edge.
  task automatic cycle();
    bit   acc;
    bit   ret;
    exp_t e;
    exp_t gone;
    acc = reset_n && in_valid && (mq.size() < 2);
    ret = reset_n && out_ready && (mq.size() > 0);
    if (reset_n && out_valid && out_ready) act_log.push_back(out_data);
    e = model_decode(in_kind, in_result, in_isNotEqual, in_isLessThan, in_overflow, in_rd, in_target);
    @(posedge clock);
    #1;
    if (!reset_n) begin
      mq.delete();
      m_cnt = 0;
      acc   = 1'b0;
    end else begin
      if (ret) begin
        gone = mq.pop_front();
        if (gone.exc && m_cnt < CMAX) m_cnt++;
      end
      if (acc) mq.push_back(e);
    end
    last_acc = acc;
    compare_outputs();
  endtask

  task automatic set_beat(input logic [2:0] k, input logic [31:0] r, input logic ne,
                          input logic lt, input logic ovf, input logic [4:0] rd,
                          input logic [31:0] t);
    in_kind       = k;
    in_result     = r;
    in_isNotEqual = ne;
    in_isLessThan = lt;
    in_overflow   = ovf;
    in_rd         = rd;
    in_target     = t;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    cycle();
    reset_n = 1'b1;
  endtask

  vec_t        tbl[8];
  logic [32:0] wide_sum;

  initial begin
    n_vec     = 0;
    n_bad     = 0;
    m_cnt     = 0;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    set_beat(3'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);

    //              kind   result        ne    lt    ovf   rd     target         we    erd    edata         redir chk
    tbl[0] = '{3'd0, 32'h0000_0002, 1'b0, 1'b0, 1'b0, 5'd5,  32'h0000_0000, 1'b1, 5'd5,  32'h0000_0002, 1'b0, 1'b1};
    tbl[1] = '{3'd1, 32'h1234_5678, 1'b0, 1'b0, 1'b1, 5'd7,  32'h0000_0010, 1'b1, 5'd30, 32'h0000_0002, 1'b0, 1'b1};
    tbl[2] = '{3'd2, 32'h0000_0037, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0000_0020, 1'b0, 5'd0,  32'h0000_0037, 1'b0, 1'b1};
    tbl[3] = '{3'd3, 32'hAAAA_0000, 1'b1, 1'b0, 1'b1, 5'd4,  32'h0000_0100, 1'b0, 5'd0,  32'h0000_0000, 1'b1, 1'b0};
    tbl[4] = '{3'd4, 32'h0000_0001, 1'b1, 1'b0, 1'b0, 5'd6,  32'h0000_0200, 1'b0, 5'd0,  32'h0000_0000, 1'b0, 1'b0};
    tbl[5] = '{3'd5, 32'h0000_DEAD, 1'b0, 1'b0, 1'b1, 5'd9,  32'h0000_0300, 1'b1, 5'd9,  32'h0000_DEAD, 1'b0, 1'b1};
    tbl[6] = '{3'd7, 32'h0000_1234, 1'b1, 1'b1, 1'b1, 5'd3,  32'h0000_0400, 1'b1, 5'd3,  32'h0000_1234, 1'b0, 1'b1};
    tbl[7] = '{3'd2, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 5'd4,  32'h0000_0500, 1'b1, 5'd30, 32'h0000_0003, 1'b0, 1'b1};

    // Reset state.
    do_reset();
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_rd", 32'(out_rd), 32'd0);
    check("rst_out_target", out_target, 32'd0);

    // Table vectors, one beat at a time with a free downstream.
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      set_beat(tbl[i].kind, tbl[i].result, tbl[i].ne, tbl[i].lt, tbl[i].ovf, tbl[i].rd, tbl[i].target);
      in_valid = 1'b1;
      cycle();
      in_valid = 1'b0;
      check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("vec%0d_we", i), 32'(out_we), 32'(tbl[i].we));
      check($sformatf("vec%0d_redirect", i), 32'(out_redirect), 32'(tbl[i].redir));
      check($sformatf("vec%0d_target", i), out_target, tbl[i].target);
      if (tbl[i].chk) begin
        check($sformatf("vec%0d_rd", i), 32'(out_rd), 32'(tbl[i].erd));
        check($sformatf("vec%0d_data", i), out_data, tbl[i].edata);
      end
      cycle();
      if (i == 0) check("vec0_exc_count", 32'(exc_count), 32'd0);
    end

    // Overflowing ADD then overflowing SUB: two status writes, count of two.
    do_reset();
    out_ready = 1'b1;
    wide_sum  = {1'b0, 32'h8000_0000} + {1'b0, 32'h8000_0000};
    set_beat(3'd0, wide_sum[31:0], 1'b0, 1'b0, wide_sum[32], 5'd8, 32'd0);
    in_valid = 1'b1;
    cycle();
    check("ovf_add_rd", 32'(out_rd), 32'd30);
    check("ovf_add_data", out_data, 32'd1);
    set_beat(3'd2, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1, 5'd8, 32'd0);
    cycle();
    check("ovf_sub_rd", 32'(out_rd), 32'd30);
    check("ovf_sub_data", out_data, 32'd3);
    in_valid = 1'b0;
    cycle();
    check("ovf_exc_count", 32'(exc_count), 32'd2);

    // Taken BLT then not-taken BNE.
    set_beat(3'd4, 32'd0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0000_0040);
    in_valid = 1'b1;
    cycle();
    check("blt_redirect", 32'(out_redirect), 32'd1);
    check("blt_target", out_target, 32'h0000_0040);
    check("blt_we", 32'(out_we), 32'd0);
    set_beat(3'd3, 32'd0, 1'b0, 1'b0, 1'b0, 5'd2, 32'h0000_0080);
    cycle();
    check("bne_redirect", 32'(out_redirect), 32'd0);
    check("bne_we", 32'(out_we), 32'd0);
    check("bne_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    cycle();

    // Backpressure: three beats offered, only two fit, order preserved.
    do_reset();
    act_log.delete();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    set_beat(3'd5, 32'h0000_00A1, 1'b0, 1'b0, 1'b0, 5'd1, 32'd0);
    cycle();
    set_beat(3'd5, 32'h0000_00B2, 1'b0, 1'b0, 1'b0, 5'd1, 32'd0);
    cycle();
    check("bp_full_in_ready", 32'(in_ready), 32'd0);
    set_beat(3'd5, 32'h0000_00C3, 1'b0, 1'b0, 1'b0, 5'd1, 32'd0);
    cycle();
    check("bp_third_held_off", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    last_acc  = 1'b0;
    for (int n = 0; n < 8 && !last_acc; n++) cycle();
    check("bp_third_accepted", 32'(last_acc), 32'd1);
    in_valid = 1'b0;
    for (int n = 0; n < 3; n++) cycle();
    check("bp_retired_count", 32'(act_log.size()), 32'd3);
    if (act_log.size() == 3) begin
      check("bp_order0", act_log[0], 32'h0000_00A1);
      check("bp_order1", act_log[1], 32'h0000_00B2);
      check("bp_order2", act_log[2], 32'h0000_00C3);
    end

    // Streaming: one beat per cycle with both handshakes held high.
    do_reset();
    act_log.delete();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 11; i++) begin
      set_beat(3'd0, 32'(100 + i), 1'b0, 1'b0, 1'b0, 5'd1, 32'd0);
      cycle();
      if (i > 0) begin
        check("stream_in_ready", 32'(in_ready), 32'd1);
        check("stream_valid", 32'(out_valid), 32'd1);
      end
    end
    check("stream_retired", 32'(act_log.size()), 32'd10);
    for (int i = 0; i < act_log.size() && i < 10; i++)
      check($sformatf("stream_data%0d", i), act_log[i], 32'(100 + i));
    in_valid = 1'b0;
    cycle();

    // Reset while full, with an exception already counted.
    do_reset();
    out_ready = 1'b1;
    set_beat(3'd1, 32'd0, 1'b0, 1'b0, 1'b1, 5'd3, 32'd0);
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    cycle();
    check("pre_rst_exc_count", 32'(exc_count), 32'd1);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    set_beat(3'd5, 32'h0000_0011, 1'b0, 1'b0, 1'b0, 5'd2, 32'h0000_0900);
    cycle();
    set_beat(3'd2, 32'h0000_0022, 1'b0, 1'b0, 1'b1, 5'd2, 32'h0000_0A00);
    cycle();
    check("pre_rst_full", 32'(in_ready), 32'd0);
    reset_n   = 1'b0;
    out_ready = 1'b1;
    cycle();
    reset_n  = 1'b1;
    in_valid = 1'b0;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_exc_count", 32'(exc_count), 32'd0);
    check("mid_rst_data", out_data, 32'd0);
    check("mid_rst_rd", 32'(out_rd), 32'd0);
    check("mid_rst_target", out_target, 32'd0);
    set_beat(3'd5, 32'h0000_0077, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    check("rd0_valid", 32'(out_valid), 32'd1);
    check("rd0_we", 32'(out_we), 32'd0);
    check("rd0_data", out_data, 32'h0000_0077);
    cycle();

    // Randomized traffic against the model, including counter saturation.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      set_beat(3'($urandom_range(0, 7)), $urandom(), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)), $urandom());
      cycle();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cycle();
    cycle();
    check("rand_drained", 32'(out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
